// File: rtl/game_state_ctrl_if.sv
// Bundle between the keypad/switch front end, the game controller and the
// Display/Seg7 blocks. The controller sits on the slave side.
interface game_state_ctrl_if #(
    parameter int SCORE_DIGITS = 4
);
    logic                      tick;
    logic                      flap_btn;
    logic                      pause_sw;
    logic                      collide;
    logic                      pass_pipe;
    logic [2:0]                state;
    logic                      flap_pulse;
    logic [4*SCORE_DIGITS-1:0] score;
    logic [4*SCORE_DIGITS-1:0] high_score;
    logic [3:0]                lives_left;
    logic                      game_over;

    modport master (
        output tick, flap_btn, pause_sw, collide, pass_pipe,
        input  state, flap_pulse, score, high_score, lives_left, game_over
    );

    modport slave (
        input  tick, flap_btn, pause_sw, collide, pass_pipe,
        output state, flap_pulse, score, high_score, lives_left, game_over
    );
endinterface

// File: rtl/game_state_ctrl.sv
// Registered game-flow FSM: idle/fly/pause/dying/over, lives, death hold-off,
// saturating BCD score and a high-score register cleared only by reset.
module game_state_ctrl #(
    parameter int SCORE_DIGITS = 4,
    parameter int LIVES        = 3,
    parameter int DEATH_HOLD   = 60
) (
    input  logic            clk,
    input  logic            rst,
    game_state_ctrl_if.slave bus
);
    localparam int SW = 4 * SCORE_DIGITS;
    localparam int HW = (DEATH_HOLD < 1) ? 1 : $clog2(DEATH_HOLD + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FLYING = 3'd1;
    localparam logic [2:0] S_PAUSED = 3'd2;
    localparam logic [2:0] S_DYING  = 3'd3;
    localparam logic [2:0] S_OVER   = 3'd4;

    localparam logic [HW-1:0] HOLD_MAX   = HW'(DEATH_HOLD);
    localparam logic [3:0]    LIVES_INIT = 4'(LIVES);

    logic [2:0]    state_q, state_d;
    logic          flap_pulse_q, flap_pulse_d;
    logic [SW-1:0] score_q, score_d;
    logic [SW-1:0] high_q, high_d;
    logic [3:0]    lives_q, lives_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          game_over_q;
    logic          flap_prev_q;

    logic                    flap_edge;
    logic [SCORE_DIGITS-1:0] nine;
    logic [SW-1:0]           score_inc;
    logic                    score_sat;

    assign flap_edge = bus.flap_btn & ~flap_prev_q;

    // BCD +1: a digit increments when every lower digit is 9, and 9 rolls to 0.
    generate
        for (genvar gi = 0; gi < SCORE_DIGITS; gi++) begin : g_bcd
            logic [3:0] digit;
            logic       cin;
            assign digit    = score_q[4*gi +: 4];
            assign nine[gi] = (digit == 4'd9);
            if (gi == 0) begin : g_lsd
                assign cin = 1'b1;
            end else begin : g_upper
                assign cin = &nine[gi-1:0];
            end
            assign score_inc[4*gi +: 4] = cin ? (nine[gi] ? 4'd0 : digit + 4'd1) : digit;
        end
    endgenerate

    // All digits at 9 means the score is pinned; it never wraps to zero.
    assign score_sat = &nine;

    // Next-state and datapath decisions for every game state.
    always_comb begin
        state_d      = state_q;
        flap_pulse_d = 1'b0;
        score_d      = score_q;
        high_d       = high_q;
        lives_d      = lives_q;
        hold_d       = hold_q;
        case (state_q)
            S_IDLE: begin
                if (flap_edge) begin
                    state_d      = S_FLYING;
                    flap_pulse_d = 1'b1;
                end
            end
            S_FLYING: begin
                if (bus.collide) begin
                    state_d = S_DYING;
                    lives_d = (lives_q != 4'd0) ? lives_q - 4'd1 : 4'd0;
                    hold_d  = '0;
                end else if (bus.pause_sw) begin
                    state_d = S_PAUSED;
                end else begin
                    if (bus.pass_pipe && !score_sat) begin
                        score_d = score_inc;
                    end
                    if (flap_edge) begin
                        flap_pulse_d = 1'b1;
                    end
                end
            end
            S_PAUSED: begin
                if (!bus.pause_sw) begin
                    state_d = S_FLYING;
                end
            end
            S_DYING: begin
                if (hold_q >= HOLD_MAX) begin
                    hold_d = '0;
                    if (lives_q == 4'd0) begin
                        state_d = S_OVER;
                        if (score_q > high_q) begin
                            high_d = score_q;
                        end
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (bus.tick) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            S_OVER: begin
                if (flap_edge) begin
                    state_d = S_IDLE;
                    score_d = '0;
                    lives_d = LIVES_INIT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; game_over is registered from the next state
    // so it lines up exactly with state==OVER.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            flap_pulse_q <= 1'b0;
            score_q      <= '0;
            high_q       <= '0;
            lives_q      <= LIVES_INIT;
            hold_q       <= '0;
            game_over_q  <= 1'b0;
            flap_prev_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            flap_pulse_q <= flap_pulse_d;
            score_q      <= score_d;
            high_q       <= high_d;
            lives_q      <= lives_d;
            hold_q       <= hold_d;
            game_over_q  <= (state_d == S_OVER);
            flap_prev_q  <= bus.flap_btn;
        end
    end

    assign bus.state      = state_q;
    assign bus.flap_pulse = flap_pulse_q;
    assign bus.score      = score_q;
    assign bus.high_score = high_q;
    assign bus.lives_left = lives_q;
    assign bus.game_over  = game_over_q;
endmodule

// File: tb/tb_game_state_ctrl.sv
// Directed bench for game_state_ctrl with hand-computed expectations.
module tb_game_state_ctrl;
    localparam int DIGITS = 4;
    localparam int HOLD   = 60;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    game_state_ctrl_if #(.SCORE_DIGITS(DIGITS)) bus ();

    game_state_ctrl #(
        .SCORE_DIGITS(DIGITS),
        .LIVES       (3),
        .DEATH_HOLD  (HOLD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
            $display("check %-14s got=%0h exp=%0h ok", tag, got, exp);
        end else begin
            $display("FAIL %-14s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic flap();
        bus.flap_btn = 1'b1;
        cyc();
        bus.flap_btn = 1'b0;
        cyc();
    endtask

    task automatic pass_n(input int n);
        bus.pass_pipe = 1'b1;
        repeat (n) cyc();
        bus.pass_pipe = 1'b0;
    endtask

    task automatic ticks(input int n);
        bus.tick = 1'b1;
        repeat (n) cyc();
        bus.tick = 1'b0;
    endtask

    task automatic die();
        bus.collide = 1'b1;
        cyc();
        bus.collide = 1'b0;
        ticks(HOLD);
    endtask

    task automatic wait_state(input string tag, input logic [2:0] target, input int budget);
        int n = 0;
        while (bus.state != target && n < budget) begin
            cyc();
            n++;
        end
        chk(tag, bus.state, target);
    endtask

    task automatic check_reset_values(input string pfx);
        chk({pfx, "_state"}, bus.state, 0);
        chk({pfx, "_pulse"}, bus.flap_pulse, 0);
        chk({pfx, "_score"}, bus.score, 0);
        chk({pfx, "_high"},  bus.high_score, 0);
        chk({pfx, "_lives"}, bus.lives_left, 3);
        chk({pfx, "_over"},  bus.game_over, 0);
    endtask

    initial begin
        int pulses;
        bus.tick = 1'b0; bus.flap_btn = 1'b0; bus.pause_sw = 1'b0;
        bus.collide = 1'b0; bus.pass_pipe = 1'b0;
        repeat (3) cyc();
        rst = 1'b0;
        cyc();
        check_reset_values("rst");

        // 1: flap edge starts flight with a single pulse
        bus.flap_btn = 1'b1;
        cyc();
        chk("t1_state", bus.state, 1);
        chk("t1_pulse", bus.flap_pulse, 1);
        cyc();
        chk("t1_pulse_end", bus.flap_pulse, 0);
        pulses = 0;
        repeat (5) begin
            cyc();
            if (bus.flap_pulse) pulses++;
        end
        chk("t1_held_pulses", pulses, 0);
        bus.flap_btn = 1'b0;
        cyc();

        // 2: BCD counting and saturation
        pass_n(123);
        chk("t2_score123", bus.score, 16'h0123);
        pass_n(9999 - 123);
        chk("t2_score9999", bus.score, 16'h9999);
        pass_n(1);
        cyc();
        chk("t2_saturate", bus.score, 16'h9999);
        chk("t2_state", bus.state, 1);

        // 3: pause ignores events
        rst = 1'b1; cyc(); rst = 1'b0;
        flap();
        pass_n(2);
        chk("t3_score", bus.score, 2);
        bus.pause_sw = 1'b1;
        cyc();
        chk("t3_paused", bus.state, 2);
        bus.pass_pipe = 1'b1; bus.collide = 1'b1; bus.flap_btn = 1'b1;
        cyc();
        bus.pass_pipe = 1'b0; bus.collide = 1'b0;
        cyc();
        chk("t3_p_state", bus.state, 2);
        chk("t3_p_score", bus.score, 2);
        chk("t3_p_pulse", bus.flap_pulse, 0);
        chk("t3_p_lives", bus.lives_left, 3);
        bus.flap_btn = 1'b0;
        bus.pause_sw = 1'b0;
        cyc();
        chk("t3_resume", bus.state, 1);

        // 4: collide beats pass_pipe; death hold then back to idle
        rst = 1'b1; cyc(); rst = 1'b0;
        flap();
        pass_n(5);
        bus.collide = 1'b1; bus.pass_pipe = 1'b1;
        cyc();
        bus.collide = 1'b0; bus.pass_pipe = 1'b0;
        chk("t4_score", bus.score, 5);
        chk("t4_dying", bus.state, 3);
        chk("t4_lives", bus.lives_left, 2);
        ticks(HOLD - 1);
        chk("t4_still_dying", bus.state, 3);
        ticks(1);
        wait_state("t4_idle", 3'd0, 4);
        chk("t4_score_kept", bus.score, 5);

        // 5: run out of lives with score 7, then new game scoring 4
        flap();
        pass_n(2);
        die();
        wait_state("t5_idle2", 3'd0, 4);
        chk("t5_lives1", bus.lives_left, 1);
        flap();
        die();
        wait_state("t5_over", 3'd4, 4);
        chk("t5_game_over", bus.game_over, 1);
        chk("t5_high", bus.high_score, 16'h0007);
        chk("t5_lives0", bus.lives_left, 0);
        flap();
        chk("t5_restart", bus.state, 0);
        chk("t5_score0", bus.score, 0);
        chk("t5_lives3", bus.lives_left, 3);
        chk("t5_go_clear", bus.game_over, 0);
        repeat (3) begin
            flap();
            if (bus.score == 0) pass_n(4);
            die();
            wait_state("t5_g2_next", (bus.lives_left == 0) ? 3'd4 : 3'd0, 4);
        end
        chk("t5_g2_score", bus.score, 4);
        chk("t5_high_kept", bus.high_score, 16'h0007);

        // 6: reset mid-hold restores everything, including high score
        flap();
        flap();
        pass_n(3);
        bus.collide = 1'b1;
        cyc();
        bus.collide = 1'b0;
        ticks(30);
        chk("t6_dying", bus.state, 3);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check_reset_values("t6");
        flap();
        bus.collide = 1'b1;
        cyc();
        bus.collide = 1'b0;
        ticks(HOLD - 1);
        chk("t6_hold_cleared", bus.state, 3);
        ticks(1);
        wait_state("t6_idle", 3'd0, 4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/game_state_ctrl.md
Name: game_state_ctrl

Overview:
Clocked game-flow controller for the Flappy Bird design. It replaces the combinational wait/fly/dead state logic with a registered FSM. It adds pause, multiple lives, a death hold-off, a BCD score counter of parametrised digit count, and a high-score register. It sits between the keypad/switch front end and the Display/Seg7 blocks, consuming collision and pipe-passed events and driving game state and score.

Parameters:
SCORE_DIGITS, 4, number of BCD digits in score/high_score
LIVES, 3, lives per game (1..15)
DEATH_HOLD, 60, number of tick strobes spent in DYING before the next state

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
tick  input  1  one-cycle frame strobe (timebase for death hold)
flap_btn  input  1  debounced flap button level
pause_sw  input  1  debounced pause switch level
collide  input  1  collision level from Display
pass_pipe  input  1  one-cycle strobe, bird cleared a pipe
state  output  3  0 IDLE, 1 FLYING, 2 PAUSED, 3 DYING, 4 OVER
flap_pulse  output  1  one-cycle flap command to bird physics
score  output  4*SCORE_DIGITS  current score, BCD, digit 0 = LSD
high_score  output  4*SCORE_DIGITS  best score since reset, BCD
lives_left  output  4  remaining lives
game_over  output  1  high while state==OVER

Behaviour:
- Reset values: state=IDLE, flap_pulse=0, score=0, high_score=0, lives_left=LIVES, game_over=0, hold counter=0, flap edge register=0.
- All outputs are registered.
- Flap edge: a rising edge is flap_btn=1 with the previous-cycle sample=0. The edge register samples in every state, including during DYING.
- IDLE:
  - Flap edge -> FLYING next cycle.
  - flap_pulse=1 in that same next cycle (latency 1 from the edge sample).
- FLYING:
  - Priority: collide > pause_sw > pass_pipe/flap.
  - collide=1 -> DYING. lives_left decrements on that transition. Hold counter clears. A pass_pipe in the same cycle is dropped.
  - Else pause_sw=1 -> PAUSED. A pass_pipe in the same cycle is dropped.
  - Else pass_pipe increments score in BCD: digit 9 rolls to 0 with a carry into the next digit.
  - Score saturates at all-9s and does not wrap.
  - Else, a flap edge gives flap_pulse=1 the next cycle.
- PAUSED:
  - pause_sw=0 -> FLYING.
  - collide, pass_pipe and flap edges are ignored. flap_pulse=0.
- DYING:
  - The hold counter increments on each tick.
  - When the count reaches DEATH_HOLD: if lives_left==0 -> OVER, else -> IDLE with the score retained.
  - Flap edges and pass_pipe are ignored.
  - Counter width is clog2(DEATH_HOLD+1).
- OVER:
  - game_over=1.
  - On the DYING->OVER transition cycle, high_score<=score if score>high_score. The comparison is an unsigned comparison of the BCD vectors.
  - Flap edge -> IDLE with score<=0 and lives_left<=LIVES, both in the same cycle.
  - This flap edge does not itself start flight. A second flap edge in IDLE is required.
- high_score is cleared only by rst.
- lives_left never underflows: the DYING->OVER path is taken once it reaches 0.
- state encodings 5..7 are unreachable. If one occurs, it goes to IDLE next cycle.
- rst asserted mid-game (any state, mid-hold) restores all reset values on the next edge, including high_score.

Test Plan:
1. rst, then a flap_btn 0->1 -> state=1 and flap_pulse high for exactly one cycle. Holding flap_btn high gives no further pulses.
2. FLYING, 123 pass_pipe strobes with SCORE_DIGITS=4 -> score=16'h0123. Preload 16'h9999 plus one strobe -> score stays 16'h9999.
3. FLYING, pause_sw=1 -> state=2. pass_pipe and collide while paused leave score and state unchanged. pause_sw=0 -> state=1.
4. collide and pass_pipe in the same cycle with score=5 -> score stays 5, state=3, lives_left=2. After 60 ticks -> state=0, score=5.
5. Lose 3 lives with final score 7 -> state=4, game_over=1, high_score=7. A flap edge -> state=0, score=0, lives_left=3. A new game scoring 4 keeps high_score=7.
6. rst pulse in DYING at hold count 30 -> next cycle all outputs at reset values, high_score=0.
